// File: rtl/trig_capture_framer_pkg.sv
// Shared definitions for the trigger/capture framer.
//   - default widths (DATA_W_DEF, ADDR_W_DEF)
//   - FSM state enum
//   - masked trigger compare
package trig_capture_framer_pkg;

  localparam int DATA_W_DEF = 33;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    POST,
    DUMP,
    GAP
  } state_e;

  // Operands are zero-extended to 64 bits by the caller so that one function
  // serves any probe width up to 64.
  function automatic logic trig_hit(input logic [63:0] probe_v,
                                    input logic [63:0] value_v,
                                    input logic [63:0] mask_v);
    return ((probe_v ^ value_v) & mask_v) == 64'd0;
  endfunction

endpackage

// File: rtl/trig_capture_framer_capture_ram.sv
// Simple dual-port sample buffer: 2**ADDR_W x DATA_W.
//   clk_i    : clock
//   we_i     : write enable, waddr_i/wdata_i written on the rising edge
//   re_i     : read enable, rdata_o updated from raddr_i on the rising edge
//   rdata_o  : registered read data (no reset, so it can map onto RAM primitives)
module capture_ram #(
  parameter int DATA_W = 33,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/trig_capture_framer.sv
// Logic-analyzer front end. Samples the probe bus into a circular buffer
// while armed, triggers on a masked pattern, captures post-trigger samples,
// then replays the buffer oldest-first as a framed word stream.
//   clock, reset_n          : clock, asynchronous active-low reset
//   probe                   : sampled bus
//   arm / abort             : start capture / cancel back to IDLE
//   trig_mask / trig_value  : trigger pattern (mask bit 1 = compared)
//   post_count              : post-trigger samples incl. trigger sample
//   data / start            : replay word and frame-valid strobe
//   busy / done             : not-IDLE flag, end-of-frame pulse
module trig_capture_framer
  import trig_capture_framer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] probe,
  input  logic              arm,
  input  logic              abort,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [ADDR_W:0]   post_count,
  output logic [DATA_W-1:0] data,
  output logic              start,
  output logic              busy,
  output logic              done
);

  localparam int              DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   valid_q, valid_d;
  logic [ADDR_W:0]   post_q;
  logic [ADDR_W:0]   post_cnt_q, post_cnt_d;
  logic [ADDR_W:0]   rem_q;
  logic              start_q, done_q;
  logic              hit, ram_we, ram_re;
  logic [DATA_W-1:0] ram_rdata;

  function automatic logic [ADDR_W:0] clamp_post(input logic [ADDR_W:0] p);
    if (p == '0)     return ONE_C;
    if (p > DEPTH_C) return DEPTH_C;
    return p;
  endfunction

  assign hit = trig_hit(64'(probe), 64'(trig_value), 64'(trig_mask));

  always_comb begin
    wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
    valid_d    = (valid_q == DEPTH_C) ? DEPTH_C : valid_q + ONE_C;
    post_cnt_d = post_cnt_q + ONE_C;
    // Oldest sample once the current write has landed; valid_d == DEPTH
    // has zero low bits, so the oldest slot is the one about to be overwritten.
    rd_ptr_d   = wr_ptr_d - valid_d[ADDR_W-1:0];
  end

  assign ram_we = (state_q == ARMED) || (state_q == POST);
  assign ram_re = (state_q == DUMP);

  capture_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (probe),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // Outputs lag the state by one cycle because of the RAM read register:
  // start is high on the cycle after each DUMP read, and done appears on the
  // cycle after GAP, which is the first start-low cycle after the frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      valid_q    <= '0;
      post_q     <= '0;
      post_cnt_q <= '0;
      rem_q      <= '0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      if (state_q != IDLE && abort) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (arm) begin
              post_q   <= clamp_post(post_count);
              wr_ptr_q <= '0;
              valid_q  <= '0;
              state_q  <= ARMED;
            end
          end
          ARMED: begin
            wr_ptr_q <= wr_ptr_d;
            valid_q  <= valid_d;
            if (hit) begin
              post_cnt_q <= ONE_C;
              if (post_q == ONE_C) begin
                rd_ptr_q <= rd_ptr_d;
                rem_q    <= valid_d;
                state_q  <= DUMP;
              end else begin
                state_q <= POST;
              end
            end
          end
          POST: begin
            wr_ptr_q   <= wr_ptr_d;
            valid_q    <= valid_d;
            post_cnt_q <= post_cnt_d;
            if (post_cnt_d == post_q) begin
              rd_ptr_q <= rd_ptr_d;
              rem_q    <= valid_d;
              state_q  <= DUMP;
            end
          end
          DUMP: begin
            start_q  <= 1'b1;
            rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            rem_q    <= rem_q - ONE_C;
            if (rem_q == ONE_C) state_q <= GAP;
          end
          GAP: begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign start = start_q;
  assign done  = done_q;
  assign busy  = (state_q != IDLE);
  // RAM output register has no reset; gating with start keeps data at 0
  // outside a frame and clears it immediately on reset.
  assign data  = start_q ? ram_rdata : '0;

endmodule

// File: tb/tb_trig_capture_framer.sv
module tb_trig_capture_framer;

  localparam int DW    = 33;
  localparam int AW    = 4;
  localparam int NCYC  = 80;
  localparam logic [DW-1:0] ALL1 = 33'h1_FFFF_FFFF;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [DW-1:0] probe;
  logic          arm, abort;
  logic [DW-1:0] trig_mask, trig_value;
  logic [AW:0]   post_count;
  logic [DW-1:0] data;
  logic          start, busy, done;

  int vectors = 0;
  int miscompares = 0;

  // results of the most recent capture run
  logic [DW-1:0] got[$];
  int   first_start, last_start, done_cnt, done_at, data_nz;
  logic busy_log [NCYC];

  always #5 clock = ~clock;

  trig_capture_framer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .probe      (probe),
    .arm        (arm),
    .abort      (abort),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .post_count (post_count),
    .data       (data),
    .start      (start),
    .busy       (busy),
    .done       (done)
  );

  // Stimulus/recording only: arm in cycle 0, probe = base + (c-1) in cycle c,
  // optional abort / second arm pulses in the given cycles (-1 = none).
  task automatic capture(input logic [DW-1:0] m, input logic [DW-1:0] v,
                         input logic [AW:0] pc, input logic [DW-1:0] base,
                         input int abort_at, input int arm2_at);
    got.delete();
    first_start = -1; last_start = -1; done_cnt = 0; done_at = -1; data_nz = 0;
    @(posedge clock); #1;
    trig_mask = m; trig_value = v; post_count = pc;
    arm = 1'b1; abort = 1'b0; probe = base;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clock);
      busy_log[c] = busy;
      if (start) begin
        if (first_start < 0) first_start = c;
        last_start = c;
        got.push_back(data);
      end else if (data !== '0) begin
        data_nz++;
      end
      if (done) begin
        done_cnt++;
        done_at = c;
      end
      @(posedge clock); #1;
      arm   = (c + 1 == arm2_at);
      abort = (c + 1 == abort_at);
      probe = base + DW'(c);
    end
    arm = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    probe = '0; arm = 1'b0; abort = 1'b0;
    trig_mask = '0; trig_value = '0; post_count = '0;
    repeat (3) @(posedge clock);
    #1;
    vectors++; if (data !== '0)  begin miscompares++; $display("FAIL reset_data got=%h exp=0", data); end
    vectors++; if (start !== 1'b0) begin miscompares++; $display("FAIL reset_start got=%b exp=0", start); end
    vectors++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (done !== 1'b0)  begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
    @(negedge clock); reset_n = 1'b1;
  endtask

  task automatic test_immediate;
    logic [DW-1:0] base;
    base = 33'h1_AAAA_0000;
    capture('0, 33'h0_1234_5678, 5'd1, base, -1, -1);
    vectors++; if (got.size() != 1) begin miscompares++; $display("FAIL imm_len got=%0d exp=1", got.size()); end
    vectors++; if (got.size() < 1 || got[0] !== base) begin miscompares++; $display("FAIL imm_word got=%h exp=%h", (got.size() > 0) ? got[0] : '0, base); end
    vectors++; if (first_start != 3) begin miscompares++; $display("FAIL imm_first_start got=%0d exp=3", first_start); end
    vectors++; if (done_cnt != 1 || done_at != 4) begin miscompares++; $display("FAIL imm_done cnt=%0d at=%0d exp cnt=1 at=4", done_cnt, done_at); end
    vectors++; if (busy_log[3] !== 1'b1 || busy_log[4] !== 1'b0) begin miscompares++; $display("FAIL imm_busy c3=%b c4=%b exp 1,0", busy_log[3], busy_log[4]); end
  endtask

  task automatic test_pattern(input int arm2_at);
    capture(ALL1, 33'd9, 5'd4, '0, -1, arm2_at);
    vectors++; if (got.size() != 13) begin miscompares++; $display("FAIL pat_len got=%0d exp=13", got.size()); end
    for (int i = 0; i < 13; i++) begin
      vectors++;
      if (i >= got.size() || got[i] !== DW'(i)) begin
        miscompares++; $display("FAIL pat_word[%0d] got=%h exp=%h", i, (i < got.size()) ? got[i] : 'x, DW'(i));
      end
    end
    vectors++; if (first_start != 15 || last_start != 27) begin miscompares++; $display("FAIL pat_window got=%0d..%0d exp=15..27", first_start, last_start); end
    vectors++; if (done_cnt != 1 || done_at != 28) begin miscompares++; $display("FAIL pat_done cnt=%0d at=%0d exp cnt=1 at=28", done_cnt, done_at); end
    vectors++; if (data_nz != 0) begin miscompares++; $display("FAIL pat_data_idle nonzero_cycles=%0d exp=0", data_nz); end
    vectors++; if (busy_log[NCYC-1] !== 1'b0) begin miscompares++; $display("FAIL pat_busy_end got=%b exp=0", busy_log[NCYC-1]); end
  endtask

  task automatic test_wrap;
    capture(ALL1, 33'd40, 5'd4, '0, -1, -1);
    vectors++; if (got.size() != 16) begin miscompares++; $display("FAIL wrap_len got=%0d exp=16", got.size()); end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (i >= got.size() || got[i] !== DW'(28 + i)) begin
        miscompares++; $display("FAIL wrap_word[%0d] got=%h exp=%h", i, (i < got.size()) ? got[i] : 'x, DW'(28 + i));
      end
    end
    vectors++; if (first_start != 46 || done_at != 62) begin miscompares++; $display("FAIL wrap_timing start=%0d done=%0d exp 46,62", first_start, done_at); end
  endtask

  task automatic test_clamp;
    capture(ALL1, 33'd9, 5'd0, '0, -1, -1);
    vectors++; if (got.size() != 10) begin miscompares++; $display("FAIL clamp0_len got=%0d exp=10", got.size()); end
    vectors++; if (got.size() < 10 || got[9] !== 33'd9 || got[0] !== 33'd0) begin miscompares++; $display("FAIL clamp0_words first/last mismatch size=%0d exp 0..9", got.size()); end
    vectors++; if (first_start != 12) begin miscompares++; $display("FAIL clamp0_first_start got=%0d exp=12", first_start); end
    capture(ALL1, 33'd5, 5'd31, '0, -1, -1);
    vectors++; if (got.size() != 16) begin miscompares++; $display("FAIL clamp31_len got=%0d exp=16", got.size()); end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (i >= got.size() || got[i] !== DW'(5 + i)) begin
        miscompares++; $display("FAIL clamp31_word[%0d] got=%h exp=%h", i, (i < got.size()) ? got[i] : 'x, DW'(5 + i));
      end
    end
    vectors++; if (first_start != 23 || done_at != 39) begin miscompares++; $display("FAIL clamp31_timing start=%0d done=%0d exp 23,39", first_start, done_at); end
  endtask

  task automatic test_abort;
    capture(ALL1, 33'd9, 5'd4, '0, 11, -1);
    vectors++; if (got.size() != 0) begin miscompares++; $display("FAIL abort_len got=%0d exp=0", got.size()); end
    vectors++; if (done_cnt != 0) begin miscompares++; $display("FAIL abort_done got=%0d exp=0", done_cnt); end
    vectors++; if (busy_log[11] !== 1'b1 || busy_log[12] !== 1'b0) begin miscompares++; $display("FAIL abort_busy c11=%b c12=%b exp 1,0", busy_log[11], busy_log[12]); end
  endtask

  task automatic test_reset_mid_dump;
    @(posedge clock); #1;
    trig_mask = ALL1; trig_value = 33'd9; post_count = 5'd4;
    arm = 1'b1; abort = 1'b0; probe = '0;
    for (int c = 0; c < 18; c++) begin
      @(posedge clock); #1;
      arm = 1'b0; probe = DW'(c);
    end
    @(negedge clock);
    vectors++; if (start !== 1'b1 || data !== 33'd3) begin miscompares++; $display("FAIL rstdump_pre start=%b data=%h exp 1,3", start, data); end
    #1 reset_n = 1'b0;
    #1;
    vectors++; if (start !== 1'b0) begin miscompares++; $display("FAIL rstdump_start got=%b exp=0", start); end
    vectors++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL rstdump_busy got=%b exp=0", busy); end
    vectors++; if (data !== '0)    begin miscompares++; $display("FAIL rstdump_data got=%h exp=0", data); end
    @(posedge clock); #1 reset_n = 1'b1;
    capture('0, '0, 5'd1, 33'h0_0000_0F0F, -1, -1);
    vectors++; if (got.size() != 1 || got[0] !== 33'h0_0000_0F0F) begin miscompares++; $display("FAIL rstdump_rearm len=%0d exp len=1 word=0f0f", got.size()); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL rstdump_rearm_done got=%0d exp=1", done_cnt); end
  endtask

  initial begin
    test_reset;
    test_immediate;
    test_pattern(-1);
    test_wrap;
    test_clamp;
    test_abort;
    test_pattern(18);
    test_reset_mid_dump;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
